// File: rtl/sobel_sequencer_if.sv
// Handshake bundle between the Sobel sequencer, its host, the window-move controller
// and the fetch/compute/write-back datapath.
interface sobel_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 12,
    parameter int CNT_W  = 24
);
    logic              start;
    logic              abort;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  length;
    logic [ADDR_W-1:0] base_addr_r;
    logic [ADDR_W-1:0] base_addr_w;
    logic              load_done;
    logic              move_done;
    logic              all_done;
    logic              read_ack;
    logic              calc_done;
    logic              write_ack;
    logic              load_initial;
    logic              start_move;
    logic [ADDR_W-1:0] initial_addr_r;
    logic [ADDR_W-1:0] initial_addr_w;
    logic              read_req;
    logic              calc_start;
    logic              write_req;
    logic              busy;
    logic              frame_done;
    logic              error;
    logic [CNT_W-1:0]  pixel_count;

    modport master (
        input  start, abort, width, length, base_addr_r, base_addr_w,
        input  load_done, move_done, all_done, read_ack, calc_done, write_ack,
        output load_initial, start_move, initial_addr_r, initial_addr_w,
        output read_req, calc_start, write_req, busy, frame_done, error, pixel_count
    );

    modport slave (
        output start, abort, width, length, base_addr_r, base_addr_w,
        output load_done, move_done, all_done, read_ack, calc_done, write_ack,
        input  load_initial, start_move, initial_addr_r, initial_addr_w,
        input  read_req, calc_start, write_req, busy, frame_done, error, pixel_count
    );
endinterface

// File: rtl/sobel_sequencer.sv
// Frame sequencer: initial load, then fetch/compute/write-back/move per output pixel,
// with per-handshake timeout and an end-of-frame pixel-count check.
module sobel_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DIM_W   = 12,
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    sobel_sequencer_if.master bus
);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int PROD_W = 2 * DIM_W;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_FETCH, S_CALC, S_WRITE, S_CHECK, S_MOVE, S_DONE, S_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_expected;
    logic [CNT_W-1:0]   r_pixel_count;
    logic [ADDR_W-1:0]  r_addr_r;
    logic [ADDR_W-1:0]  r_addr_w;
    logic               r_load_initial;
    logic               r_start_move;
    logic               r_read_req;
    logic               r_calc_start;
    logic               r_write_req;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_error;

    logic               w_start_ok;
    logic               w_dims_bad;
    logic               w_wait_state;
    logic               w_ack;
    logic               w_timeout;
    logic [PROD_W-1:0]  w_prod;

    assign w_start_ok = bus.start &&
                        (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_dims_bad = (bus.width < DIM_W'(3)) || (bus.length < DIM_W'(3));
    assign w_prod     = PROD_W'(bus.width - DIM_W'(2)) * PROD_W'(bus.length - DIM_W'(2));

    assign w_wait_state = (r_state == S_LOAD) || (r_state == S_FETCH) || (r_state == S_CALC) ||
                          (r_state == S_WRITE) || (r_state == S_MOVE);

    always_comb begin
        w_ack = 1'b0;
        case (r_state)
            S_LOAD:  w_ack = bus.load_done;
            S_FETCH: w_ack = bus.read_ack;
            S_CALC:  w_ack = bus.calc_done;
            S_WRITE: w_ack = bus.write_ack;
            S_MOVE:  w_ack = bus.move_done;
            default: w_ack = 1'b0;
        endcase
    end

    // An ack arriving in the final allowed cycle still wins over the timeout.
    assign w_timeout = w_wait_state && !w_ack && (r_timer == TMR_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        if (w_start_ok) begin
            w_next = w_dims_bad ? S_ERROR : S_LOAD;
        end else if (bus.abort && r_state != S_IDLE) begin
            w_next = S_IDLE;
        end else if (w_timeout) begin
            w_next = S_ERROR;
        end else begin
            case (r_state)
                S_LOAD:  if (bus.load_done) w_next = S_FETCH;
                S_FETCH: if (bus.read_ack)  w_next = S_CALC;
                S_CALC:  if (bus.calc_done) w_next = S_WRITE;
                S_WRITE: if (bus.write_ack) w_next = S_CHECK;
                S_CHECK: begin
                    if (bus.all_done)
                        w_next = (r_pixel_count == r_expected) ? S_DONE : S_ERROR;
                    else
                        w_next = S_MOVE;
                end
                S_MOVE:  if (bus.move_done) w_next = S_FETCH;
                default: w_next = r_state;
            endcase
        end
    end

    // Outputs are decoded from the next state so every strobe is a registered Moore output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_pixel_count  <= '0;
            r_addr_r       <= '0;
            r_addr_w       <= '0;
            r_load_initial <= 1'b0;
            r_start_move   <= 1'b0;
            r_read_req     <= 1'b0;
            r_calc_start   <= 1'b0;
            r_write_req    <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_load_initial <= (w_next == S_LOAD);
            r_read_req     <= (w_next == S_FETCH);
            r_calc_start   <= (w_next == S_CALC);
            r_write_req    <= (w_next == S_WRITE);
            r_start_move   <= (w_next == S_MOVE);
            r_busy         <= !(w_next inside {S_IDLE, S_DONE, S_ERROR});
            r_frame_done   <= (w_next == S_DONE) && (r_state != S_DONE);

            if (w_next != r_state || !w_wait_state)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;

            if (w_start_ok) begin
                r_expected    <= CNT_W'(w_prod);
                r_addr_r      <= bus.base_addr_r;
                r_addr_w      <= bus.base_addr_w;
                r_pixel_count <= '0;
                r_error       <= w_dims_bad;
            end else begin
                if (r_state == S_WRITE && w_next == S_CHECK && r_pixel_count != '1)
                    r_pixel_count <= r_pixel_count + 1'b1;
                if (w_next == S_ERROR)
                    r_error <= 1'b1;
            end
        end
    end

    assign bus.load_initial   = r_load_initial;
    assign bus.start_move     = r_start_move;
    assign bus.initial_addr_r = r_addr_r;
    assign bus.initial_addr_w = r_addr_w;
    assign bus.read_req       = r_read_req;
    assign bus.calc_start     = r_calc_start;
    assign bus.write_req      = r_write_req;
    assign bus.busy           = r_busy;
    assign bus.frame_done     = r_frame_done;
    assign bus.error          = r_error;
    assign bus.pixel_count    = r_pixel_count;
endmodule

// File: tb/tb_sobel_sequencer.sv
// Bench for sobel_sequencer: table of frames, randomized frames against a transaction-level
// model of the handshake protocol, and hand-written timeout/abort/reset sequences.
module tb_sobel_sequencer;
    localparam int ADDR_W = 8;
    localparam int DIM_W  = 12;
    localparam int CNT_W  = 24;
    localparam int TMO    = 8;

    localparam logic [4:0] P_NONE  = 5'b00000;
    localparam logic [4:0] P_LOAD  = 5'b10000;
    localparam logic [4:0] P_FETCH = 5'b01000;
    localparam logic [4:0] P_CALC  = 5'b00100;
    localparam logic [4:0] P_WRITE = 5'b00010;
    localparam logic [4:0] P_MOVE  = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sobel_sequencer_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CNT_W(CNT_W)) bus ();

    sobel_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int w, l, nw, dly, mdly;
        bit poke, noise, exp_err;
        int exp_cnt;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit noise_en = 0;
    bit poke_start = 0;
    int cur_w = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bus.load_initial, bus.read_req, bus.calc_start, bus.write_req, bus.start_move};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.abort = 0;
        bus.load_done = 0; bus.move_done = 0; bus.all_done = 0;
        bus.read_ack = 0; bus.calc_done = 0; bus.write_ack = 0;
    endtask

    // Every ack except the one awaited is either idle or random noise.
    task automatic drive_noise(input logic [4:0] phase);
        bus.load_done = noise_en && phase != P_LOAD  && $urandom_range(0, 1) == 1;
        bus.read_ack  = noise_en && phase != P_FETCH && $urandom_range(0, 1) == 1;
        bus.calc_done = noise_en && phase != P_CALC  && $urandom_range(0, 1) == 1;
        bus.write_ack = noise_en && phase != P_WRITE && $urandom_range(0, 1) == 1;
        bus.move_done = noise_en && phase != P_MOVE  && $urandom_range(0, 1) == 1;
        bus.all_done  = noise_en && $urandom_range(0, 1) == 1;
    endtask

    task automatic set_ack(input logic [4:0] phase);
        case (phase)
            P_LOAD:  bus.load_done = 1;
            P_FETCH: bus.read_ack  = 1;
            P_CALC:  bus.calc_done = 1;
            P_WRITE: bus.write_ack = 1;
            default: bus.move_done = 1;
        endcase
    endtask

    // Expects the strobe for 'phase' to be up now, acks after dly cycles, checks it stayed up.
    task automatic serve(input logic [4:0] phase, input int dly, input string name);
        int hi;
        hi = 0;
        chk({name, " strobe"}, strobes(), phase);
        chk({name, " busy"}, bus.busy, 1);
        for (int i = 0; i < dly; i++) begin
            if (strobes() == phase) hi++;
            drive_noise(phase);
            if (poke_start && phase == P_FETCH && i == 0) begin
                bus.start = 1; bus.width = 2; poke_start = 0;
            end
            tick();
            bus.start = 0; bus.width = DIM_W'(cur_w);
        end
        if (strobes() == phase) hi++;
        drive_noise(phase);
        set_ack(phase);
        tick();
        clear_inputs();
        chk({name, " high cycles"}, hi, dly + 1);
    endtask

    task automatic run_frame(input vec_t v, input string name);
        logic [ADDR_W-1:0] ar, aw;
        ar = ADDR_W'($urandom); aw = ADDR_W'($urandom);
        cur_w = v.w;
        noise_en = v.noise;
        poke_start = v.poke;
        bus.width = DIM_W'(v.w); bus.length = DIM_W'(v.l);
        bus.base_addr_r = ar; bus.base_addr_w = aw;
        bus.start = 1;
        tick();
        bus.start = 0;
        if (v.w < 3 || v.l < 3) begin
            chk({name, " small error"}, bus.error, 1);
            chk({name, " small strobes"}, strobes(), P_NONE);
            chk({name, " small busy"}, bus.busy, 0);
            chk({name, " small count"}, bus.pixel_count, 0);
            return;
        end
        chk({name, " addr_r"}, bus.initial_addr_r, ar);
        chk({name, " addr_w"}, bus.initial_addr_w, aw);
        chk({name, " error cleared"}, bus.error, 0);
        serve(P_LOAD, v.dly, {name, " load"});
        for (int p = 1; p <= v.nw; p++) begin
            serve(P_FETCH, v.dly, {name, " fetch"});
            serve(P_CALC, v.dly, {name, " calc"});
            serve(P_WRITE, v.dly, {name, " write"});
            chk({name, " check strobes"}, strobes(), P_NONE);
            chk({name, " check busy"}, bus.busy, 1);
            chk({name, " running count"}, bus.pixel_count, p);
            drive_noise(P_NONE);
            bus.all_done = (p == v.nw);
            tick();
            clear_inputs();
            if (p < v.nw) serve(P_MOVE, v.mdly, {name, " move"});
        end
        chk({name, " frame_done"}, bus.frame_done, !v.exp_err);
        chk({name, " error"}, bus.error, v.exp_err);
        chk({name, " end busy"}, bus.busy, 0);
        chk({name, " end strobes"}, strobes(), P_NONE);
        chk({name, " pixel_count"}, bus.pixel_count, v.exp_cnt);
        tick();
        chk({name, " frame_done pulse"}, bus.frame_done, 0);
        noise_en = 0;
    endtask

    task automatic begin_frame();
        noise_en = 0;
        cur_w = 5;
        bus.width = 5; bus.length = 5; bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t rv;
        int   cnt;
        int   exp_px;

        tbl[0] = '{w:5, l:5,  nw:9, dly:1, mdly:1, poke:0, noise:0, exp_err:0, exp_cnt:9};
        tbl[1] = '{w:5, l:5,  nw:9, dly:1, mdly:4, poke:0, noise:0, exp_err:0, exp_cnt:9};
        tbl[2] = '{w:4, l:4,  nw:3, dly:1, mdly:1, poke:0, noise:0, exp_err:1, exp_cnt:3};
        tbl[3] = '{w:2, l:5,  nw:0, dly:0, mdly:0, poke:0, noise:0, exp_err:1, exp_cnt:0};
        tbl[4] = '{w:3, l:3,  nw:1, dly:0, mdly:0, poke:0, noise:1, exp_err:0, exp_cnt:1};
        tbl[5] = '{w:5, l:5,  nw:9, dly:2, mdly:1, poke:1, noise:0, exp_err:0, exp_cnt:9};
        tbl[6] = '{w:3, l:6,  nw:4, dly:0, mdly:2, poke:0, noise:1, exp_err:0, exp_cnt:4};

        clear_inputs();
        bus.width = 0; bus.length = 0; bus.base_addr_r = 0; bus.base_addr_w = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        chk("reset strobes", strobes(), P_NONE);
        chk("reset busy", bus.busy, 0);
        chk("reset frame_done", bus.frame_done, 0);
        chk("reset error", bus.error, 0);
        chk("reset pixel_count", bus.pixel_count, 0);
        chk("reset addr_r", bus.initial_addr_r, 0);
        chk("reset addr_w", bus.initial_addr_w, 0);

        foreach (tbl[i]) run_frame(tbl[i], $sformatf("vec%0d", i));

        // Randomized frames; the model predicts the count from frame geometry alone.
        for (int k = 0; k < 25; k++) begin
            rv.w = $urandom_range(2, 7);
            rv.l = $urandom_range(2, 7);
            exp_px = (rv.w - 2) * (rv.l - 2);
            case ($urandom_range(0, 4))
                0:       rv.nw = exp_px - 1;
                1:       rv.nw = exp_px + 1;
                default: rv.nw = exp_px;
            endcase
            if (rv.nw < 1) rv.nw = 1;
            rv.dly = $urandom_range(0, 4);
            rv.mdly = $urandom_range(0, 4);
            rv.poke = 0;
            rv.noise = 1;
            rv.exp_err = (rv.w < 3 || rv.l < 3) || (rv.nw != exp_px);
            rv.exp_cnt = (rv.w < 3 || rv.l < 3) ? 0 : rv.nw;
            run_frame(rv, $sformatf("rnd%0d", k));
        end

        // Timeout in CALC, then recovery with a fresh start.
        begin_frame();
        serve(P_LOAD, 1, "tmo load");
        serve(P_FETCH, 1, "tmo fetch");
        chk("tmo calc entry", strobes(), P_CALC);
        cnt = 0;
        while (strobes() == P_CALC && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("tmo cycles", cnt, TMO);
        chk("tmo error", bus.error, 1);
        chk("tmo strobes", strobes(), P_NONE);
        chk("tmo busy", bus.busy, 0);
        begin_frame();
        chk("tmo restart load", strobes(), P_LOAD);
        chk("tmo restart error", bus.error, 0);
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("abort load strobes", strobes(), P_NONE);
        chk("abort load busy", bus.busy, 0);

        // Abort in WRITE with a simultaneous write_ack: count held.
        begin_frame();
        serve(P_LOAD, 0, "ab load");
        serve(P_FETCH, 0, "ab fetch");
        serve(P_CALC, 0, "ab calc");
        serve(P_WRITE, 0, "ab write");
        tick();
        serve(P_MOVE, 0, "ab move");
        serve(P_FETCH, 0, "ab fetch2");
        serve(P_CALC, 0, "ab calc2");
        chk("ab write entry", strobes(), P_WRITE);
        bus.abort = 1; bus.write_ack = 1;
        tick();
        clear_inputs();
        chk("ab write_req", bus.write_req, 0);
        chk("ab strobes", strobes(), P_NONE);
        chk("ab busy", bus.busy, 0);
        chk("ab pixel_count", bus.pixel_count, 1);
        chk("ab error", bus.error, 0);

        // Reset while in MOVE.
        begin_frame();
        serve(P_LOAD, 0, "rs load");
        serve(P_FETCH, 0, "rs fetch");
        serve(P_CALC, 0, "rs calc");
        serve(P_WRITE, 0, "rs write");
        tick();
        chk("rs move entry", strobes(), P_MOVE);
        reset = 1;
        tick();
        reset = 0;
        chk("rs strobes", strobes(), P_NONE);
        chk("rs busy", bus.busy, 0);
        chk("rs frame_done", bus.frame_done, 0);
        chk("rs error", bus.error, 0);
        chk("rs pixel_count", bus.pixel_count, 0);
        chk("rs addr_r", bus.initial_addr_r, 0);
        chk("rs addr_w", bus.initial_addr_w, 0);
        tick();
        chk("rs idle hold", strobes(), P_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
